// File: rtl/fifo_stream_reader.sv
//------------------------------------------------------------------------------
// Module   : fifo_stream_reader
// Brief    : Pops a show-ahead FIFO into a 2-entry buffer and streams it out
//            as valid/ready beats with burst framing and beat/burst counters.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  beat_cnt_o,
  output logic [CNT_WIDTH-1:0]  burst_cnt_o
);

  localparam int              IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [IDX_W-1:0]      beat_idx_q, beat_idx_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;

  logic w_pop;
  logic w_xfer;

  // Pop decision uses only registered occupancy, keeping out_ready off this path.
  assign w_pop  = !reset_i && (state_q == ST_RUN) && !fifo_empty_i && (occ_q != 2'd2);
  assign w_xfer = (occ_q != 2'd0) && out_ready_i;

  always_ff @(posedge rd_clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      occ_q       <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      beat_idx_q  <= '0;
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      beat_idx_q  <= beat_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable_i) state_d = ((occ_q == 2'd0) && !w_pop) ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (enable_i)               state_d = ST_RUN;
        else if (occ_q == 2'd0)     state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case ({w_pop, w_xfer})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) head_d = fifo_rd_data_i;
        else               tail_d = fifo_rd_data_i;
      end
      2'b01: begin
        occ_d  = occ_q - 2'd1;
        head_d = tail_q;
      end
      2'b11: begin
        // Head leaves and the new word lands behind whatever remains.
        head_d = (occ_q == 2'd1) ? fifo_rd_data_i : tail_q;
        tail_d = fifo_rd_data_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    beat_idx_d  = beat_idx_q;
    beat_cnt_d  = beat_cnt_q;
    burst_cnt_d = burst_cnt_q;
    if (w_xfer) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
      if (beat_idx_q == LAST_IDX) begin
        beat_idx_d  = '0;
        burst_cnt_d = burst_cnt_q + 1'b1;
      end else begin
        beat_idx_d = beat_idx_q + 1'b1;
      end
    end
  end

  assign fifo_rd_en_o = w_pop;
  assign out_valid_o  = (occ_q != 2'd0);
  assign out_data_o   = head_q;
  assign out_last_o   = (occ_q != 2'd0) && (beat_idx_q == LAST_IDX);
  assign busy_o       = (state_q != ST_IDLE);
  assign beat_cnt_o   = beat_cnt_q;
  assign burst_cnt_o  = burst_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
//------------------------------------------------------------------------------
// Module   : tb_fifo_stream_reader
// Brief    : Randomized and directed bench with a queue-based FIFO and stream model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0, fifo_empty = 1'b1, ready = 1'b0;
  logic [DW-1:0] fifo_data = '0;
  logic          rd_en, valid, last, busy;
  logic [DW-1:0] odata;
  logic [CW-1:0] beat_cnt, burst_cnt;

  logic          en1 = 1'b0, empty1 = 1'b1, rdy1 = 1'b0;
  logic [DW-1:0] data1 = '0;
  logic          rd_en1, valid1, last1, busy1;
  logic [DW-1:0] odata1;
  logic [CW-1:0] beat1, burst1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$], sb[$], q1[$], sb1[$];
  bit            hold_empty = 1'b0;
  int            mdl_beats = 0, mdl_occ = 0, pops = 0;
  bit            prev_valid = 1'b0, prev_xfer = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  bit            m_xfer;
  logic [DW-1:0] m_exp;
  logic          m_explast;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
    .rd_clk_i(clk), .reset_i(rst), .enable_i(enable), .fifo_empty_i(fifo_empty),
    .fifo_rd_data_i(fifo_data), .fifo_rd_en_o(rd_en), .out_valid_o(valid),
    .out_ready_i(ready), .out_data_o(odata), .out_last_o(last), .busy_o(busy),
    .beat_cnt_o(beat_cnt), .burst_cnt_o(burst_cnt)
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(1), .CNT_WIDTH(CW)) dut1 (
    .rd_clk_i(clk), .reset_i(rst), .enable_i(en1), .fifo_empty_i(empty1),
    .fifo_rd_data_i(data1), .fifo_rd_en_o(rd_en1), .out_valid_o(valid1),
    .out_ready_i(rdy1), .out_data_o(odata1), .out_last_o(last1), .busy_o(busy1),
    .beat_cnt_o(beat1), .burst_cnt_o(burst1)
  );

  always #5 clk = ~clk;

  // Reference: output stream equals push order; beat k (from reset) is last iff k%BL==BL-1.
  always @(posedge clk) begin
    if (rst) begin
      checks++;
      if (rd_en !== 1'b0) begin errors++; $display("FAIL rd_en_in_reset got=%b exp=0", rd_en); end
      mdl_beats = 0; mdl_occ = 0; pops = 0; prev_valid = 0; prev_xfer = 0;
    end else begin
      checks++;
      if (rd_en && (fifo_empty || mdl_occ >= 2)) begin
        errors++; $display("FAIL pop_guard rd_en=%b empty=%b occ=%0d", rd_en, fifo_empty, mdl_occ);
      end
      checks++;
      if (valid !== (mdl_occ != 0)) begin
        errors++; $display("FAIL valid_occ got=%b exp_occ=%0d", valid, mdl_occ);
      end
      if (prev_valid && !prev_xfer) begin
        checks++;
        if (!valid || odata !== prev_data || last !== prev_last) begin
          errors++; $display("FAIL hold got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                             valid, odata, last, prev_data, prev_last);
        end
      end
      m_xfer = valid && ready;
      if (m_xfer) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL beat_unexpected got=%h exp=none", odata);
        end else begin
          m_exp = sb.pop_front();
          m_explast = ((mdl_beats % BL) == BL - 1);
          if (odata !== m_exp || last !== m_explast) begin
            errors++; $display("FAIL beat got d=%h l=%b exp d=%h l=%b", odata, last, m_exp, m_explast);
          end
        end
        mdl_beats++;
      end
      if (rd_en) begin
        pops++; mdl_occ++;
        if (q.size() > 0) void'(q.pop_front());
      end
      if (m_xfer) mdl_occ--;
      prev_valid = valid; prev_xfer = m_xfer; prev_data = odata; prev_last = last;

      if (rd_en1 && q1.size() > 0) void'(q1.pop_front());
      if (valid1 && rdy1) begin
        checks++;
        if (sb1.size() == 0) begin
          errors++; $display("FAIL bl1_unexpected got=%h exp=none", odata1);
        end else begin
          m_exp = sb1.pop_front();
          if (odata1 !== m_exp || last1 !== 1'b1) begin
            errors++; $display("FAIL bl1_beat got d=%h l=%b exp d=%h l=1", odata1, last1, m_exp);
          end
        end
      end
    end
  end

  task automatic refresh();
    fifo_empty = hold_empty || (q.size() == 0);
    fifo_data  = (q.size() > 0) ? q[0] : 8'hA5;
    empty1     = (q1.size() == 0);
    data1      = (q1.size() > 0) ? q1[0] : 8'h5A;
  endtask

  task automatic step();
    @(negedge clk);
    refresh();
    if (!rst) begin
      checks++;
      if (beat_cnt !== CW'(mdl_beats) || burst_cnt !== CW'(mdl_beats / BL)) begin
        errors++; $display("FAIL counters got beat=%0d burst=%0d exp beat=%0d burst=%0d",
                           beat_cnt, burst_cnt, mdl_beats, mdl_beats / BL);
      end
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    q.push_back(v); sb.push_back(v); refresh();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 0; ready = 0; hold_empty = 0; en1 = 0; rdy1 = 0;
    q.delete(); sb.delete(); q1.delete(); sb1.delete();
    refresh();
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int g = 0;
    while ((sb.size() != 0 || sb1.size() != 0) && g < bound) begin step(); g++; end
    checks++;
    if (sb.size() != 0 || sb1.size() != 0) begin
      errors++; $display("FAIL %s_timeout left=%0d exp=0", name, sb.size() + sb1.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b1; ready = 1'b1;
    push(8'h33); push(8'h44);
    step(); step(); #1;
    checks++;
    if (rd_en !== 0 || valid !== 0 || odata !== 0 || last !== 0 || busy !== 0 ||
        beat_cnt !== 0 || burst_cnt !== 0) begin
      errors++; $display("FAIL reset_state got rd=%b v=%b d=%h l=%b b=%b bc=%0d uc=%0d exp all 0",
                         rd_en, valid, odata, last, busy, beat_cnt, burst_cnt);
    end
  endtask

  task automatic test_stream();
    int expc;
    do_reset();
    enable = 1'b1; ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    for (int n = 1; n <= 11; n++) begin
      step();
      expc = (n < 2) ? 0 : ((n - 2 > 8) ? 8 : n - 2);
      checks++;
      if (beat_cnt !== CW'(expc)) begin
        errors++; $display("FAIL stream_rate n=%0d got=%0d exp=%0d", n, beat_cnt, expc);
      end
    end
    checks++;
    if (burst_cnt !== 2 || sb.size() != 0) begin
      errors++; $display("FAIL stream_bursts got=%0d left=%0d exp=2 left=0", burst_cnt, sb.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    enable = 1'b1; ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    repeat (6) step();
    #1;
    checks++;
    if (pops != 2 || rd_en !== 0 || odata !== 8'h10 || valid !== 1 || q.size() != 3) begin
      errors++; $display("FAIL backpressure got pops=%0d rd=%b d=%h v=%b fifo=%0d exp 2 0 10 1 3",
                         pops, rd_en, odata, valid, q.size());
    end
    ready = 1'b1;
    wait_drain("backpressure", 50);
    checks++;
    if (beat_cnt !== 5) begin
      errors++; $display("FAIL backpressure_cnt got=%0d exp=5", beat_cnt);
    end
  endtask

  task automatic test_burst1();
    do_reset();
    en1 = 1'b1; rdy1 = 1'b1;
    for (int i = 0; i < 3; i++) begin q1.push_back(8'hC0 + 8'(i)); sb1.push_back(8'hC0 + 8'(i)); end
    refresh();
    wait_drain("burst1", 20);
    step();
    checks++;
    if (burst1 !== 3 || beat1 !== 3) begin
      errors++; $display("FAIL burst1_cnt got beat=%0d burst=%0d exp 3 3", beat1, burst1);
    end
    en1 = 1'b0;
  endtask

  task automatic test_drain();
    int g = 0;
    do_reset();
    enable = 1'b1; ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    while (pops < 2 && g < 20) begin step(); g++; end
    enable = 1'b0; refresh();
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      checks++;
      if (rd_en !== 0 || busy !== 1 || valid !== 1 || pops != 2) begin
        errors++; $display("FAIL drain_hold got rd=%b busy=%b v=%b pops=%0d exp 0 1 1 2",
                           rd_en, busy, valid, pops);
      end
    end
    ready = 1'b1;
    repeat (4) step();
    checks++;
    if (busy !== 0 || beat_cnt !== 2 || valid !== 0 || q.size() != 3) begin
      errors++; $display("FAIL drain_done got busy=%b beats=%0d v=%b fifo=%0d exp 0 2 0 3",
                         busy, beat_cnt, valid, q.size());
    end
    sb.delete();
  endtask

  task automatic test_random();
    int pushed = 0, g = 0;
    do_reset();
    enable = 1'b1;
    while ((pushed < 1000 || sb.size() != 0) && g < 30000) begin
      step();
      if (pushed < 1000 && q.size() < 4 && ($urandom % 4) != 0) begin
        push(8'($urandom)); pushed++;
      end
      ready      = (($urandom % 3) != 0);
      hold_empty = (($urandom % 5) == 0);
      if (($urandom % 40) == 0) enable = ~enable;
      if (pushed == 1000 && sb.size() != 0 && q.size() == 0) enable = 1'b1;
      refresh();
      g++;
    end
    step();
    checks++;
    if (sb.size() != 0 || beat_cnt !== 1000 || burst_cnt !== 250) begin
      errors++; $display("FAIL random got left=%0d beats=%0d bursts=%0d exp 0 1000 250",
                         sb.size(), beat_cnt, burst_cnt);
    end
    hold_empty = 1'b0;
  endtask

  task automatic test_reset_mid();
    int g = 0;
    do_reset();
    enable = 1'b1; ready = 1'b1;
    push(8'h01); push(8'h02);
    repeat (4) step();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
    while (mdl_occ < 2 && g < 20) begin step(); g++; end
    checks++;
    if (beat_cnt !== 2 || valid !== 1) begin
      errors++; $display("FAIL reset_mid_setup got beats=%0d v=%b exp 2 1", beat_cnt, valid);
    end
    rst = 1'b1; q.delete(); sb.delete(); refresh();
    step();
    checks++;
    if (valid !== 0 || beat_cnt !== 0 || burst_cnt !== 0) begin
      errors++; $display("FAIL reset_mid got v=%b beats=%0d bursts=%0d exp 0 0 0",
                         valid, beat_cnt, burst_cnt);
    end
    rst = 1'b0; ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h80 + 8'(i));
    wait_drain("reset_mid", 30);
    step();
    checks++;
    if (burst_cnt !== 1 || beat_cnt !== 4) begin
      errors++; $display("FAIL reset_mid_burst got bursts=%0d beats=%0d exp 1 4", burst_cnt, beat_cnt);
    end
  endtask

  initial begin
    refresh();
    test_reset();
    test_stream();
    test_backpressure();
    test_burst1();
    test_drain();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
